alu_exec_stage: RTL and testbench

- Execute stage sitting directly downstream of the ALU operation decoder. It consumes the 4-bit Operation code, the operands, and the branch and writeback control signals.
- Computes the ALU result and the branch decision, then registers them into the EX/MEM output slot.
- Valid/ready handshakes on both sides. Shifts run on an iterative multi-cycle shifter that back-pressures the ID/EX side.

---
 rtl/alu_exec_pkg.sv | 37 +++
 rtl/alu_exec_stage_iter_shifter.sv | 56 +++++
 rtl/alu_exec_stage.sv | 149 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute stage.
// Op codes mirror the decoder's 4-bit Operation field.
package alu_exec_pkg;

   localparam int XLEN_DEF = 32;
   localparam int SHAMT_W  = 5;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_XOR  = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLL  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SRA  = 4'b0111,
      OP_SUB  = 4'b1000,
      OP_SLT  = 4'b1001,
      OP_PASS = 4'b1100,
      OP_OR   = 4'b1101
   } alu_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_stage_iter_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bit positions per cycle.
// value_nxt/done describe the step taken this cycle, so the owner can commit the final step directly.
module iter_shifter
   import alu_exec_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int SHIFT_STEP = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [XLEN-1:0]    load_value,
   input  logic [SHAMT_W-1:0] load_shamt,
   input  logic [3:0]         load_mode,
   output logic [XLEN-1:0]    value_nxt,
   output logic               done
);

   localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHIFT_STEP);

   logic [XLEN-1:0]    value;
   logic [SHAMT_W-1:0] remaining;
   logic [SHAMT_W-1:0] rem_nxt;
   logic [SHAMT_W-1:0] amt;
   logic [3:0]         mode;

   always_comb begin
      amt = '0;
      if ({1'b0, remaining} < STEP) amt = remaining;
      else                          amt = STEP[SHAMT_W-1:0];
      rem_nxt = remaining - amt;
      done    = (rem_nxt == '0);
      case (mode)
         OP_SLL:  value_nxt = value << amt;
         OP_SRA:  value_nxt = $signed(value) >>> amt;
         default: value_nxt = value >> amt;
      endcase
   end

   // Stepping continues after completion; a zero remaining count makes it a no-op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value     <= '0;
         remaining <= '0;
         mode      <= OP_SRL;
      end else if (load) begin
         value     <= load_value;
         remaining <= load_shamt;
         mode      <= load_mode;
      end else begin
         value     <= value_nxt;
         remaining <= rem_nxt;
      end
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU result and branch decision into a registered EX/MEM slot.
// Shifts go through the iterative shifter and stall the ID/EX side while busy.
module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int SHIFT_STEP = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      Operation,
   input  logic            Branch,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [XLEN-1:0] PCPlus4,
   input  logic            RegWrite,
   input  logic [4:0]      rd,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUResult,
   output logic            BrTaken,
   output logic            RegWrite_out,
   output logic [4:0]      rd_out
);

   state_e          state, state_nxt;
   logic [XLEN-1:0] alu_res;
   logic            br_cond, br_taken;
   logic            slot_free, accept, op_shift;
   logic            sh_load, slot_wr_alu, slot_wr_sh;
   logic [XLEN-1:0] sh_value;
   logic            sh_done;
   logic            cap_rw, cap_br;
   logic [4:0]      cap_rd;

   always_comb begin
      alu_res = '0;
      case (Operation)
         OP_AND:  alu_res = SrcA & SrcB;
         OP_XOR:  alu_res = SrcA ^ SrcB;
         OP_OR:   alu_res = SrcA | SrcB;
         OP_ADD:  alu_res = SrcA + SrcB;
         OP_SUB:  alu_res = SrcA - SrcB;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_PASS: alu_res = PCPlus4;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (Funct3)
         F3_BEQ:  br_cond = (SrcA == SrcB);
         F3_BNE:  br_cond = (SrcA != SrcB);
         F3_BLT:  br_cond = ($signed(SrcA) <  $signed(SrcB));
         F3_BGE:  br_cond = ($signed(SrcA) >= $signed(SrcB));
         F3_BLTU: br_cond = (SrcA <  SrcB);
         F3_BGEU: br_cond = (SrcA >= SrcB);
         default: br_cond = 1'b0;
      endcase
      br_taken = Branch && br_cond;
   end

   assign slot_free   = !out_valid || out_ready;
   assign in_ready    = (state == IDLE) && slot_free;
   assign accept      = in_valid && in_ready && !flush;
   assign op_shift    = is_shift(Operation);
   assign sh_load     = accept && op_shift;
   assign slot_wr_alu = accept && !op_shift;

   iter_shifter #(
      .XLEN       (XLEN),
      .SHIFT_STEP (SHIFT_STEP)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (sh_load),
      .load_value (SrcA),
      .load_shamt (SrcB[SHAMT_W-1:0]),
      .load_mode  (Operation),
      .value_nxt  (sh_value),
      .done       (sh_done)
   );

   // Flush outranks completion: a squashed shift never reaches the slot.
   always_comb begin
      state_nxt  = state;
      slot_wr_sh = 1'b0;
      case (state)
         IDLE:  if (sh_load) state_nxt = SHIFT;
         SHIFT: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (sh_done && slot_free) begin
               slot_wr_sh = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_rw <= 1'b0;
         cap_br <= 1'b0;
         cap_rd <= '0;
      end else if (sh_load) begin
         cap_rw <= RegWrite;
         cap_br <= br_taken;
         cap_rd <= rd;
      end
   end

   // A write in the same cycle as a drain keeps the slot full with new data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         ALUResult    <= '0;
         BrTaken      <= 1'b0;
         RegWrite_out <= 1'b0;
         rd_out       <= '0;
      end else if (slot_wr_alu) begin
         out_valid    <= 1'b1;
         ALUResult    <= alu_res;
         BrTaken      <= br_taken;
         RegWrite_out <= RegWrite;
         rd_out       <= rd;
      end else if (slot_wr_sh) begin
         out_valid    <= 1'b1;
         ALUResult    <= sh_value;
         BrTaken      <= cap_br;
         RegWrite_out <= cap_rw;
         rd_out       <= cap_rd;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage against a behavioural model.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [3:0]  Operation;
   logic        Branch;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB, PCPlus4;
   logic        RegWrite;
   logic [4:0]  rd;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] ALUResult;
   logic        BrTaken, RegWrite_out;
   logic [4:0]  rd_out;

   int n_chk  = 0;
   int n_fail = 0;

   alu_exec_stage #(.XLEN(32), .SHIFT_STEP(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Operation(Operation), .Branch(Branch), .Funct3(Funct3),
      .SrcA(SrcA), .SrcB(SrcB), .PCPlus4(PCPlus4), .RegWrite(RegWrite), .rd(rd),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .ALUResult(ALUResult), .BrTaken(BrTaken), .RegWrite_out(RegWrite_out), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, b, pc);
      int sh = int'(b[4:0]);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a ^ b;
         4'b0010: return a + b;
         4'b0100: return a << sh;
         4'b0101: return a >> sh;
         4'b0111: return $signed(a) >>> sh;
         4'b1001: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1101: return a | b;
         4'b1000: return a - b;
         4'b1100: return pc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_br(input logic br, input logic [2:0] f3, input logic [31:0] a, b);
      if (!br) return 1'b0;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) <  $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a <  b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
      int sh = int'(b[4:0]);
      if (op != 4'b0100 && op != 4'b0101 && op != 4'b0111) return 1;
      if (sh == 0) return 2;
      return (sh + 3) / 4 + 1;
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, b, pc,
                        input logic br, input logic [2:0] f3, input logic rw, input logic [4:0] r);
      Operation = op; SrcA = a; SrcB = b; PCPlus4 = pc;
      Branch = br; Funct3 = f3; RegWrite = rw; rd = r;
   endtask

   // Issue one op with out_ready=1 and check latency and all slot fields.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, b, pc,
                         input logic br, input logic [2:0] f3, input logic rw, input logic [4:0] r);
      int w = 0;
      int lat;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      check({tag, ".ready"}, 32'(in_ready), 32'd1);
      if (!in_ready) return;
      drive(op, a, b, pc, br, f3, rw, r);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(ref_lat(op, b)));
      check({tag, ".res"}, ALUResult, ref_res(op, a, b, pc));
      check({tag, ".br"},  32'(BrTaken), 32'(ref_br(br, f3, a, b)));
      check({tag, ".rw"},  32'(RegWrite_out), 32'(rw));
      check({tag, ".rd"},  32'(rd_out), 32'(r));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ops [13];
      logic [31:0] prev;
      int          cnt;
      ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h7, 4'h9, 4'hD, 4'h8, 4'hC, 4'h3, 4'h6, 4'hF};

      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(4'h0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0);
      #1;
      check("rst.ov", 32'(out_valid), 32'd0);
      check("rst.res", ALUResult, 32'd0);
      check("rst.br", 32'(BrTaken), 32'd0);
      check("rst.rw", 32'(RegWrite_out), 32'd0);
      check("rst.rd", 32'(rd_out), 32'd0);
      check("rst.ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      run_op("add", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 3'd0, 1'b1, 5'd7);
      check("add.ovf", ALUResult, 32'h80000000);

      // SRA by 9: three busy cycles, slot fills on the fourth edge
      drive(4'b0111, 32'h80000000, 32'd9, 32'd0, 1'b0, 3'd0, 1'b1, 5'd12);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("sra.busy", 32'(in_ready), 32'd0);
         check("sra.ov0", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      check("sra.ov1", 32'(out_valid), 32'd1);
      check("sra.res", ALUResult, 32'hFFC00000);
      check("sra.rd", 32'(rd_out), 32'd12);

      run_op("sra0", 4'b0111, 32'h80000000, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 5'd1);
      run_op("blt",  4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 3'd4, 1'b0, 5'd0);
      check("blt.taken", 32'(BrTaken), 32'd1);
      run_op("bltu", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 3'd6, 1'b0, 5'd0);
      check("bltu.taken", 32'(BrTaken), 32'd0);
      run_op("bne",  4'b1000, 32'h1234, 32'h1234, 32'd0, 1'b1, 3'd1, 1'b0, 5'd0);
      check("bne.taken", 32'(BrTaken), 32'd0);

      // back-pressure: slot full, then drain and reload in one cycle
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(4'b0010, 32'd5, 32'd6, 32'd0, 1'b0, 3'd0, 1'b1, 5'd3);
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(4'b0001, 32'hFF, 32'h0F, 32'd0, 1'b0, 3'd0, 1'b1, 5'd4);
      for (int i = 0; i < 5; i++) begin
         check("bp.ready", 32'(in_ready), 32'd0);
         check("bp.ov", 32'(out_valid), 32'd1);
         check("bp.res", ALUResult, 32'd11);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1 check("bp.ready1", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp.reload.ov", 32'(out_valid), 32'd1);
      check("bp.reload.res", ALUResult, ref_res(4'b0001, 32'hFF, 32'h0F, 32'd0));
      check("bp.reload.rd", 32'(rd_out), 32'd4);
      @(posedge clk); #1;
      check("bp.drain", 32'(out_valid), 32'd0);

      // flush mid-shift: no slot write, previous data retained
      prev = ref_res(4'b0001, 32'hFF, 32'h0F, 32'd0);
      drive(4'b0100, 32'd1, 32'd31, 32'd0, 1'b0, 3'd0, 1'b1, 5'd9);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("fl.idle", 32'(in_ready), 32'd1);
      check("fl.ov", 32'(out_valid), 32'd0);
      check("fl.res", ALUResult, prev);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      check("fl.nowrite", 32'(cnt), 32'd0);
      run_op("fl.add", 4'b0010, 32'd100, 32'd23, 32'd0, 1'b0, 3'd0, 1'b1, 5'd2);

      // flush with in_valid in IDLE suppresses the accept
      @(posedge clk); #1;
      drive(4'b0010, 32'd1, 32'd1, 32'd0, 1'b0, 3'd0, 1'b1, 5'd5);
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flidle.ov", 32'(out_valid), 32'd0);
      check("flidle.ready", 32'(in_ready), 32'd1);

      // randomized ops
      for (int n = 0; n < 60; n++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = ops[$urandom_range(12, 0)];
         a  = $urandom();
         b  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(31, 0)) : $urandom();
         if ($urandom_range(7, 0) == 0) b = a;
         run_op("rnd", op, a, b, $urandom(), 1'($urandom_range(1, 0)),
                3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)));
      end

      // async reset mid-shift
      run_op("pre", 4'b0010, 32'h11, 32'h22, 32'd0, 1'b0, 3'd0, 1'b1, 5'd9);
      drive(4'b0101, 32'hFFFFFFFF, 32'd31, 32'd0, 1'b1, 3'd1, 1'b1, 5'd6);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("ar.ov", 32'(out_valid), 32'd0);
      check("ar.res", ALUResult, 32'd0);
      check("ar.br", 32'(BrTaken), 32'd0);
      check("ar.rw", 32'(RegWrite_out), 32'd0);
      check("ar.rd", 32'(rd_out), 32'd0);
      #1 reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      check("ar.discard", 32'(cnt), 32'd0);
      run_op("ar.add", 4'b0010, 32'd40, 32'd2, 32'd0, 1'b0, 3'd0, 1'b1, 5'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
